// File: rtl/reaction_scorer_if.sv
// rtl/reaction_scorer_if.sv - player/display signal bundle for the reaction scorer
interface reaction_scorer_if;
    logic       start;
    logic       btn;
    logic       stimulus;
    logic [3:0] round_no;
    logic [3:0] score;
    logic       over;

    modport master (output start, btn, input stimulus, round_no, score, over);
    modport slave  (input start, btn, output stimulus, round_no, score, over);
endinterface

// File: rtl/reaction_scorer.sv
// rtl/reaction_scorer.sv - reflex game FSM: timed rounds, hit counting, final score
// Optional feature macro: RANDOM_DELAY_EN (LFSR-based pre-stimulus delay).
module reaction_scorer #(
    parameter int NO_ROUNDS       = 10,
    parameter int TICKS_PER_MS    = 2000,
    parameter int REACT_WINDOW_MS = 500,
    parameter int DELAY_MS        = 1000,
    parameter int MIN_DELAY_MS    = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    reaction_scorer_if.slave   game
);
    // ms counter sized to cover every delay or window any build can ask for
    localparam int MS_SPAN = DELAY_MS + MIN_DELAY_MS + 1024 + REACT_WINDOW_MS;
    localparam int CNT_W   = $clog2(MS_SPAN);
    localparam int PW      = $clog2(TICKS_PER_MS + 1);

    localparam logic [PW-1:0]    TICK_LAST  = PW'(TICKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(REACT_WINDOW_MS - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NO_ROUNDS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARMED, S_RELEASE, S_DONE} state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] ms_cnt;
    logic [CNT_W-1:0] delay_last;
    logic             btn_q;
    logic             stimulus;
    logic [3:0]       round_no;
    logic [3:0]       score;
    logic             over;
    logic             ms_tick;
    logic             press;

    assign ms_tick = (presc == TICK_LAST);
    assign press   = game.btn & ~btn_q;

`ifdef RANDOM_DELAY_EN
    logic [9:0] lfsr;
    logic       load_delay;

    assign load_delay = ((state == S_IDLE || state == S_DONE) && game.start) ||
                        (state == S_RELEASE && !game.btn && round_no != LAST_ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= 10'h3FF;
            delay_last <= CNT_W'(DELAY_MS - 1);
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            if (load_delay)
                delay_last <= CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr) - CNT_W'(1);
        end
    end
`else
    assign delay_last = CNT_W'(DELAY_MS - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            ms_cnt   <= '0;
            btn_q    <= 1'b0;
            stimulus <= 1'b0;
            round_no <= 4'd0;
            score    <= 4'd0;
            over     <= 1'b0;
        end else begin
            btn_q <= game.btn;
            presc <= ms_tick ? '0 : presc + PW'(1);
            // every transition below also restarts the prescaler
            case (state)
                S_IDLE, S_DONE: begin
                    if (game.start) begin
                        state    <= S_WAIT;
                        round_no <= 4'd1;
                        score    <= 4'd0;
                        over     <= 1'b0;
                        ms_cnt   <= '0;
                        presc    <= '0;
                    end
                end
                S_WAIT: begin
                    if (press) begin
                        state <= S_RELEASE;
                        presc <= '0;
                    end else if (ms_tick) begin
                        if (ms_cnt == delay_last) begin
                            state    <= S_ARMED;
                            stimulus <= 1'b1;
                            ms_cnt   <= '0;
                            presc    <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + CNT_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    // expiry takes priority over a press on the same cycle
                    if (ms_tick && ms_cnt == WIN_LAST) begin
                        state    <= S_RELEASE;
                        stimulus <= 1'b0;
                        presc    <= '0;
                    end else if (press) begin
                        if (score != LAST_ROUND)
                            score <= score + 4'd1;
                        state    <= S_RELEASE;
                        stimulus <= 1'b0;
                        presc    <= '0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    stimulus <= 1'b0;
                    if (!game.btn) begin
                        presc  <= '0;
                        ms_cnt <= '0;
                        if (round_no == LAST_ROUND) begin
                            state <= S_DONE;
                            over  <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            round_no <= round_no + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign game.stimulus = stimulus;
    assign game.round_no = round_no;
    assign game.score    = score;
    assign game.over     = over;
endmodule
